// File: rtl/mesi_isc_pkg.sv
// Shared MESI intersection-controller codes: mbus commands, cbus
// commands, broadcast entry types and broadcast snoop FSM states.
package mesi_isc_pkg;

   // Main-bus commands issued by CPUs toward the controller.
   localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
   localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
   localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
   localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
   localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

   // Coherence-bus commands driven to each CPU. Codes 5-7 are unused.
   typedef enum logic [2:0] {
      CBUS_CMD_NOP      = 3'd0,
      CBUS_CMD_WR_SNOOP = 3'd1,
      CBUS_CMD_RD_SNOOP = 3'd2,
      CBUS_CMD_EN_WR    = 3'd3,
      CBUS_CMD_EN_RD    = 3'd4
   } cbus_cmd_e;

   // Broadcast FIFO entry types.
   typedef enum logic [1:0] {
      BROAD_TYPE_NOP = 2'd0,
      BROAD_TYPE_WR  = 2'd1,
      BROAD_TYPE_RD  = 2'd2,
      BROAD_TYPE_ILL = 2'd3
   } broad_type_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SNOOP  = 2'd1,
      ST_ENABLE = 2'd2
   } broad_state_e;

endpackage

// File: rtl/mesi_isc_ack_tracker.sv
// Per-CPU acknowledge latch for the broadcast snoop controller.
// Ports: clk, rst (sync, active high), clr, set[3:0], mask[3:0]
// (CPUs that must ack), acked[3:0], all_acked.
module mesi_isc_ack_tracker (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [3:0] set,
   input  logic [3:0] mask,
   output logic [3:0] acked,
   output logic       all_acked
);

   always_ff @(posedge clk) begin
      if (rst || clr) acked <= 4'b0000;
      else            acked <= acked | set;
   end

   // Acks arriving this cycle count, so the last acks and the
   // transition to ENABLE can share one edge.
   assign all_acked = &(acked | set | ~mask);

endmodule

// File: rtl/mesi_isc_broad_snoop_cntl.sv
// Broadcast snoop controller: pops the broadcast FIFO, snoops the
// other three CPUs, then enables the originator on the cbus.
// Ports: clk, rst, broad FIFO head/empty in, cbus acks in;
// FIFO pop, cbus addr/cmd/id, busy and sticky error out.
module mesi_isc_broad_snoop_cntl
   import mesi_isc_pkg::*;
#(
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 7,
   parameter int CBUS_CMD_WIDTH   = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        broad_fifo_status_empty_i,
   input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
   input  logic [1:0]                  broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
   input  logic [3:0]                  cbus_ack_array_i,
   output logic                        broad_fifo_rd_o,
   output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
   output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
   output logic [BROAD_ID_WIDTH-1:0]   cbus_id_o,
   output logic                        broad_busy_o,
   output logic                        broad_err_o
);

   broad_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [BROAD_TYPE_WIDTH-1:0] type_q;
   logic [1:0]                  cpu_q;
   logic [BROAD_ID_WIDTH-1:0]   id_q;
   logic                        err_q;

   logic       pop;
   logic       busy;
   logic       head_ok;
   logic       is_wr;
   logic       ack_clr;
   logic [3:0] orig_mask;
   logic [3:0] snoop_active;
   logic [3:0] ack_set;
   logic [3:0] acked;
   logic       all_acked;
   logic [2:0] snoop_code;
   logic [2:0] en_code;

   assign head_ok =
      (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_TYPE_WR)) ||
      (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_TYPE_RD));

   assign is_wr      = (type_q == BROAD_TYPE_WIDTH'(BROAD_TYPE_WR));
   assign snoop_code = is_wr ? CBUS_CMD_WR_SNOOP : CBUS_CMD_RD_SNOOP;
   assign en_code    = is_wr ? CBUS_CMD_EN_WR : CBUS_CMD_EN_RD;

   assign orig_mask = 4'b0001 << cpu_q;

   // CPUs still owed a snoop command; only these may set an ack.
   assign snoop_active = (state_q == ST_SNOOP) ?
                         (~orig_mask & ~acked) : 4'b0000;
   assign ack_set = rst ? 4'b0000 : (cbus_ack_array_i & snoop_active);

   mesi_isc_ack_tracker u_ack_tracker (
      .clk       (clk),
      .rst       (rst),
      .clr       (ack_clr),
      .set       (ack_set),
      .mask      (~orig_mask),
      .acked     (acked),
      .all_acked (all_acked)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      busy    = 1'b0;
      ack_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!broad_fifo_status_empty_i) begin
               pop = 1'b1;
               if (head_ok) state_d = ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            busy = 1'b1;
            if (all_acked) state_d = ST_ENABLE;
         end
         ST_ENABLE: begin
            busy = 1'b1;
            if (|(cbus_ack_array_i & orig_mask)) begin
               state_d = ST_IDLE;
               ack_clr = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) begin
         pop     = 1'b0;
         busy    = 1'b0;
         ack_clr = 1'b0;
      end
   end

   always_comb begin
      cbus_cmd_array_o = '0;
      for (int n = 0; n < 4; n++) begin
         if (snoop_active[n])
            cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
               CBUS_CMD_WIDTH'(snoop_code);
         else if (state_q == ST_ENABLE && orig_mask[n])
            cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
               CBUS_CMD_WIDTH'(en_code);
      end
      if (rst) cbus_cmd_array_o = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         type_q  <= '0;
         cpu_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            addr_q <= broad_addr_i;
            type_q <= broad_type_i;
            cpu_q  <= broad_cpu_id_i;
            id_q   <= broad_id_i;
            if (!head_ok) err_q <= 1'b1;
         end
      end
   end

   assign broad_fifo_rd_o = pop;
   assign cbus_addr_o     = addr_q;
   assign cbus_id_o       = id_q;
   assign broad_busy_o    = busy;
   assign broad_err_o     = err_q;

endmodule

// File: tb/tb_mesi_isc_broad_snoop_cntl.sv
// Testbench for mesi_isc_broad_snoop_cntl: FIFO model, scoreboard
// of expected cbus transactions, per-scenario checking tasks.
module tb_mesi_isc_broad_snoop_cntl;

   localparam int AW = 32;
   localparam int TW = 2;
   localparam int IW = 7;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          empty;
   logic [AW-1:0] baddr;
   logic [TW-1:0] btype;
   logic [1:0]    bcpu;
   logic [IW-1:0] bid;
   logic [3:0]    ack;
   logic          rd;
   logic [AW-1:0] caddr;
   logic [4*CW-1:0] cmd;
   logic [IW-1:0] cid;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   mesi_isc_broad_snoop_cntl #(
      .ADDR_WIDTH       (AW),
      .BROAD_TYPE_WIDTH (TW),
      .BROAD_ID_WIDTH   (IW),
      .CBUS_CMD_WIDTH   (CW)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .broad_fifo_status_empty_i (empty),
      .broad_addr_i              (baddr),
      .broad_type_i              (btype),
      .broad_cpu_id_i            (bcpu),
      .broad_id_i                (bid),
      .cbus_ack_array_i          (ack),
      .broad_fifo_rd_o           (rd),
      .cbus_addr_o               (caddr),
      .cbus_cmd_array_o          (cmd),
      .cbus_id_o                 (cid),
      .broad_busy_o              (busy),
      .broad_err_o               (err)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [1:0]    typ;
      logic [1:0]    cpu;
      logic [IW-1:0] id;
   } ent_t;

   ent_t fifo[$];
   ent_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pops   = 0;

   function automatic logic [11:0] snoop_cmds(
      input logic [1:0] orig, input logic [2:0] c,
      input logic [3:0] done);
      logic [11:0] r;
      r = '0;
      for (int n = 0; n < 4; n++)
         if (n != int'(orig) && !done[n]) r[n*3 +: 3] = c;
      return r;
   endfunction

   function automatic logic [11:0] en_cmds(
      input logic [1:0] orig, input logic [2:0] c);
      logic [11:0] r;
      r = '0;
      r[orig*3 +: 3] = c;
      return r;
   endfunction

   task automatic drive_head();
      if (fifo.size() == 0) begin
         empty = 1'b1;
         baddr = '0;
         btype = '0;
         bcpu  = '0;
         bid   = '0;
      end else begin
         empty = 1'b0;
         baddr = fifo[0].addr;
         btype = fifo[0].typ;
         bcpu  = fifo[0].cpu;
         bid   = fifo[0].id;
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [1:0] t,
                       input logic [1:0] c, input logic [IW-1:0] i);
      ent_t e;
      e.addr = a; e.typ = t; e.cpu = c; e.id = i;
      fifo.push_back(e);
      if (t == 2'd1 || t == 2'd2) exp_q.push_back(e);
      drive_head();
      #1;
   endtask

   // One clock: rd is sampled mid-cycle, the FIFO model pops on the
   // edge, outputs are then stable for checking.
   task automatic tick();
      logic rd_at;
      ent_t tmp;
      @(negedge clk);
      rd_at = rd;
      @(posedge clk);
      #1;
      if (rd_at) begin
         checks++;
         if (fifo.size() == 0) begin
            errors++;
            $display("FAIL pop_empty: rd=1 required no pop");
         end else begin
            tmp = fifo.pop_front();
            pops++;
         end
      end
      drive_head();
      #1;
   endtask

   // Scoreboard comparison of the ENABLE phase against the oldest
   // expected transaction.
   task automatic sb_enable(input string nm);
      ent_t e;
      logic [2:0] c;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         c = (e.typ == 2'd1) ? 3'd3 : 3'd4;
         if (cmd !== en_cmds(e.cpu, c) || caddr !== e.addr ||
             cid !== e.id || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s: cmd=%h addr=%h id=%h busy=%b required cmd=%h addr=%h id=%h busy=1",
                     nm, cmd, caddr, cid, busy,
                     en_cmds(e.cpu, c), e.addr, e.id);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ack = 4'b0000;
      drive_head();
      tick();
      tick();
      checks++;
      if (cmd !== '0 || busy !== 1'b0 || err !== 1'b0 ||
          caddr !== '0 || cid !== '0 || rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: cmd=%h busy=%b err=%b addr=%h id=%h rd=%b required all 0",
                  cmd, busy, err, caddr, cid, rd);
      end
      fifo.push_back('{32'hDEAD, 2'd1, 2'd0, 7'd1});
      drive_head();
      #1;
      checks++;
      if (rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pop: rd=%b required 0", rd);
      end
      fifo.delete();
      drive_head();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_wr_all_acks();
      int p0;
      p0 = pops;
      push(32'h100, 2'd1, 2'd1, 7'd5);
      checks++;
      if (rd !== 1'b1) begin
         errors++;
         $display("FAIL wr_pop_comb: rd=%b required 1", rd);
      end
      tick();
      checks++;
      if (cmd !== snoop_cmds(2'd1, 3'd1, 4'b0) || busy !== 1'b1 ||
          caddr !== 32'h100 || cid !== 7'd5) begin
         errors++;
         $display("FAIL wr_snoop: cmd=%h busy=%b addr=%h id=%h required cmd=%h busy=1 addr=100 id=5",
                  cmd, busy, caddr, cid, snoop_cmds(2'd1, 3'd1, 4'b0));
      end
      ack = 4'b1101;
      tick();
      ack = 4'b0000;
      sb_enable("wr_enable");
      ack = 4'b0010;
      tick();
      ack = 4'b0000;
      checks++;
      if (busy !== 1'b0 || cmd !== '0 || pops - p0 != 1) begin
         errors++;
         $display("FAIL wr_idle: busy=%b cmd=%h pops=%0d required busy=0 cmd=0 pops=1",
                  busy, cmd, pops - p0);
      end
   endtask

   task automatic test_rd_staggered();
      logic [3:0] seq [3];
      logic [3:0] done;
      seq[0] = 4'b1000;
      seq[1] = 4'b0010;
      seq[2] = 4'b0100;
      done = 4'b0000;
      push(32'h2A0, 2'd2, 2'd0, 7'h11);
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (cmd !== snoop_cmds(2'd0, 3'd2, done) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_stagger_%0d: cmd=%h busy=%b required cmd=%h busy=1",
                     k, cmd, busy, snoop_cmds(2'd0, 3'd2, done));
         end
         ack = seq[k];
         done = done | seq[k];
         tick();
         ack = 4'b0000;
      end
      sb_enable("rd_enable");
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rd_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_stray_ack();
      push(32'h3C4, 2'd1, 2'd0, 7'h22);
      tick();
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
      checks++;
      if (cmd !== snoop_cmds(2'd0, 3'd1, 4'b0)) begin
         errors++;
         $display("FAIL stray_ignored: cmd=%h required %h",
                  cmd, snoop_cmds(2'd0, 3'd1, 4'b0));
      end
      ack = 4'b0011;
      tick();
      checks++;
      if (cmd !== snoop_cmds(2'd0, 3'd1, 4'b0010)) begin
         errors++;
         $display("FAIL stray_partial: cmd=%h required %h",
                  cmd, snoop_cmds(2'd0, 3'd1, 4'b0010));
      end
      ack = 4'b1101;
      tick();
      sb_enable("stray_enable");
      // Acks from non-originators in ENABLE must not finish it.
      ack = 4'b1110;
      tick();
      checks++;
      if (cmd !== en_cmds(2'd0, 3'd3) || busy !== 1'b1) begin
         errors++;
         $display("FAIL stray_enable_hold: cmd=%h busy=%b required cmd=%h busy=1",
                  cmd, busy, en_cmds(2'd0, 3'd3));
      end
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_illegal();
      int p0;
      p0 = pops;
      push(32'h44, 2'd3, 2'd2, 7'h33);
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (err !== 1'b1 || cmd !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_%0d: err=%b cmd=%h busy=%b required err=1 cmd=0 busy=0",
                     k, err, cmd, busy);
         end
         tick();
      end
      checks++;
      if (pops - p0 != 1) begin
         errors++;
         $display("FAIL illegal_pops: pops=%0d required 1", pops - p0);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (rd !== 1'b0) begin
            errors++;
            $display("FAIL empty_no_pop_%0d: rd=%b required 0", k, rd);
         end
         tick();
      end
      p0 = pops;
      push(32'h500, 2'd2, 2'd2, 7'h40);
      push(32'h600, 2'd1, 2'd3, 7'h41);
      tick();
      checks++;
      if (rd !== 1'b0 || cmd !== snoop_cmds(2'd2, 3'd2, 4'b0)) begin
         errors++;
         $display("FAIL b2b_snoop_a: rd=%b cmd=%h required rd=0 cmd=%h",
                  rd, cmd, snoop_cmds(2'd2, 3'd2, 4'b0));
      end
      ack = 4'b1011;
      tick();
      sb_enable("b2b_enable_a");
      checks++;
      if (rd !== 1'b0) begin
         errors++;
         $display("FAIL b2b_enable_no_pop: rd=%b required 0", rd);
      end
      ack = 4'b0100;
      tick();
      ack = 4'b0000;
      checks++;
      if (rd !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_repop: rd=%b busy=%b required rd=1 busy=0",
                  rd, busy);
      end
      tick();
      checks++;
      if (cmd !== snoop_cmds(2'd3, 3'd1, 4'b0) || caddr !== 32'h600) begin
         errors++;
         $display("FAIL b2b_snoop_b: cmd=%h addr=%h required cmd=%h addr=600",
                  cmd, caddr, snoop_cmds(2'd3, 3'd1, 4'b0));
      end
      ack = 4'b0111;
      tick();
      sb_enable("b2b_enable_b");
      ack = 4'b1000;
      tick();
      ack = 4'b0000;
      checks++;
      if (busy !== 1'b0 || pops - p0 != 2 || fifo.size() != 0) begin
         errors++;
         $display("FAIL b2b_done: busy=%b pops=%0d fifo=%0d required busy=0 pops=2 fifo=0",
                  busy, pops - p0, fifo.size());
      end
   endtask

   task automatic test_reset_mid();
      ent_t tmp;
      push(32'h700, 2'd2, 2'd1, 7'h55);
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: busy=%b required 1", busy);
      end
      // The popped entry is abandoned by reset.
      tmp = exp_q.pop_back();
      rst = 1'b1;
      tick();
      checks++;
      if (cmd !== '0 || busy !== 1'b0 || rd !== 1'b0 ||
          caddr !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: cmd=%h busy=%b rd=%b addr=%h err=%b required all 0",
                  cmd, busy, rd, caddr, err);
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (cmd !== '0 || busy !== 1'b0 || rd !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: cmd=%h busy=%b rd=%b required all 0",
                  cmd, busy, rd);
      end
   endtask

   initial begin
      rst = 1'b1;
      ack = 4'b0000;
      drive_head();
      test_reset();
      test_wr_all_acks();
      test_rd_staggered();
      test_stray_ack();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d required 0",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mesi_isc_broad_snoop_cntl.md
MESI_ISC_BROAD_SNOOP_CNTL -- requirements
Module: mesi_isc_broad_snoop_cntl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, broadcast and coherence-bus address width.
REQ-002 SHALL have parameter BROAD_TYPE_WIDTH, default 2, broadcast type width.
REQ-003 SHALL have parameter BROAD_ID_WIDTH, default 7, broadcast transaction id width.
REQ-004 SHALL have parameter CBUS_CMD_WIDTH, default 3, per-CPU coherence command width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port broad_fifo_status_empty_i, input, 1, the broadcast FIFO is empty.
REQ-008 SHALL have port broad_addr_i, input, ADDR_WIDTH, address at the broadcast FIFO head (show-ahead).
REQ-009 SHALL have port broad_type_i, input, BROAD_TYPE_WIDTH, head type: 0 NOP, 1 WR, 2 RD, 3 illegal.
REQ-010 SHALL have port broad_cpu_id_i, input, 2, CPU that originated the head request.
REQ-011 SHALL have port broad_id_i, input, BROAD_ID_WIDTH, head transaction id.
REQ-012 SHALL have port cbus_ack_array_i, input, 4, per-CPU acknowledge of the current cbus command.
REQ-013 SHALL have port broad_fifo_rd_o, output, 1, pop strobe to the broadcast FIFO.
REQ-014 SHALL have port cbus_addr_o, output, ADDR_WIDTH, address of the transaction in progress.
REQ-015 SHALL have port cbus_cmd_array_o, output, 4*CBUS_CMD_WIDTH, per-CPU command; CPU n in bits [(n+1)*3-1:n*3].
REQ-016 SHALL have port cbus_id_o, output, BROAD_ID_WIDTH, id of the transaction in progress.
REQ-017 SHALL have port broad_busy_o, output, 1, a transaction is in progress.
REQ-018 SHALL have port broad_err_o, output, 1, sticky flag set after an illegal or NOP entry is seen.

Function
REQ-019 SHALL use cbus commands NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4; codes 5-7 SHALL never be driven.
REQ-020 SHALL implement the FSM IDLE, SNOOP, ENABLE; it SHALL leave ENABLE only to IDLE.
REQ-021 In IDLE with broad_fifo_status_empty_i=0, broad_fifo_rd_o SHALL be 1 combinationally and addr/type/cpu_id/id SHALL be latched on that edge.
REQ-022 broad_fifo_rd_o SHALL be 0 in every other state and whenever the FIFO is empty, so the block never pops an empty FIFO.
REQ-023 A latched type WR or RD SHALL move IDLE->SNOOP; type NOP or 3 SHALL set broad_err_o, return to IDLE, and issue no cbus command.
REQ-024 In SNOOP, each CPU other than the originator SHALL be driven WR_SNOOP (type WR) or RD_SNOOP (type RD) until it acks; the originator SHALL be driven NOP.
REQ-025 An ack SHALL be latched per CPU; from the cycle after its ack, that CPU SHALL be driven NOP.
REQ-026 Acks from CPUs not currently driven a non-NOP command SHALL be ignored.
REQ-027 When all three snooped CPUs have acked, including acks arriving in the same cycle, SNOOP SHALL go to ENABLE on the next edge.
REQ-028 In ENABLE, the originator SHALL be driven EN_WR or EN_RD and the others NOP; the originator's ack SHALL return to IDLE and clear the ack latches.
REQ-029 cbus_addr_o and cbus_id_o SHALL hold the latched values from the pop until the next pop.
REQ-030 broad_busy_o SHALL be 1 in SNOOP and ENABLE.
REQ-031 Minimum latency from pop to IDLE SHALL be 3 cycles: pop edge, one SNOOP cycle with all acks, one ENABLE cycle with ack.
REQ-032 A new pop SHALL occur no earlier than the cycle IDLE is re-entered, giving back-to-back transactions with no idle gap.
REQ-033 There SHALL be no timeout; the FSM waits for acks indefinitely.

Reset
REQ-034 While rst=1, the FSM SHALL be IDLE, all cbus commands NOP, ack latches 0, cbus_addr_o=0, cbus_id_o=0, broad_busy_o=0, broad_err_o=0 and broad_fifo_rd_o=0.
REQ-035 Reset mid-transaction SHALL abandon it without re-issuing it; a popped entry is lost.

Structure
REQ-036 Cbus command codes, broad type codes and the FSM state enum SHALL live in the shared mesi_isc package alongside the existing mbus codes.
REQ-037 There SHALL be one sub-module, mesi_isc_ack_tracker, holding the 4-bit ack latch with set, clear and all-acked detection.

Verification
REQ-038 Bench: FIFO head WR from cpu 1, addr 0x100, with all acks the cycle after each command -> cpu0/2/3 get cmd 1, cpu1 gets NOP, then cpu1 gets cmd 3; exactly one pop; idle after 3 cycles.
REQ-039 Bench: RD from cpu 0 with acks from cpu3, then cpu1, then cpu2 on separate cycles -> each acked CPU drops to NOP in the next cycle; EN_RD (4) to cpu0 only after cpu2's ack.
REQ-040 Bench: stray ack on cpu0 during SNOOP of a cpu0-originated request -> ignored; ENABLE is reached only after cpu1/2/3 ack.
REQ-041 Bench: head type 3 -> one pop, broad_err_o=1 permanently, cbus_cmd_array_o stays 0.
REQ-042 Bench: FIFO empty for 10 cycles -> broad_fifo_rd_o stays 0; then two queued entries -> second pop in the same cycle IDLE is re-entered.
REQ-043 Bench: rst asserted in SNOOP -> next cycle all commands NOP, state IDLE, no pop while the FIFO is empty.
